// File: rtl/mac_dot_acc.sv
// ============================================================================
//  Module      : mac_dot_acc
//  Description : Pipelined dot-product accumulator. Each accepted beat
//                multiplies LANES operand pairs, reduces the products
//                through a balanced adder tree and adds the tree sum into
//                an accumulator seeded with a bias:
//                  mac_out = in_c + sum(beats) sum(lanes) a*b
//                Supports INT8 (signed low byte per lane, wrap-around
//                16-bit sums) and FP16 (IEEE half, round-to-nearest-even,
//                subnormals flushed to zero).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          : clock, asynchronous active-high reset
//    start             : job request, accepted in IDLE only
//    mode              : 0 = INT8, 1 = FP16 (latched at start)
//    len               : job length minus one, in beats (latched at start)
//    in_c              : accumulator seed (latched at start)
//    in_valid/in_ready : operand beat handshake
//    in_a, in_b        : LANES x 16-bit operands, lane k at [16k+15:16k]
//    out_valid/out_ready : result handshake
//    mac_out           : accumulated result
//    error             : sticky FP16 multiplier overflow/underflow flag
//    busy              : high whenever the FSM is not in IDLE
//  Configuration
//    MAC_TREE_REG_EN   : when defined, a register stage sits after the
//                        adder tree (last accept to out_valid = 4 cycles);
//                        otherwise the tree feeds the accumulator adder
//                        directly (3 cycles).
// ============================================================================
`default_nettype none

module mac_dot_acc #(
  parameter int LANES = 4,
  parameter int LEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [LEN_W-1:0]    len,
  input  logic [15:0]         in_c,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*LANES-1:0] in_a,
  input  logic [16*LANES-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         mac_out,
  output logic                error,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // --------------------------------------------------------------------------
  // Arithmetic cores (non-pipelined)
  // --------------------------------------------------------------------------
  // FP16 multiply; returns {err, result}. err flags a finite product that
  // overflowed to infinity or underflowed below the smallest normal.
  function automatic logic [16:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic              s;
    logic [4:0]        ea;
    logic [4:0]        eb;
    logic [21:0]       p;
    logic [10:0]       top;
    logic [11:0]       m;
    logic              g;
    logic              st;
    logic signed [7:0] e;
    logic [16:0]       r;
    s   = a[15] ^ b[15];
    ea  = a[14:10];
    eb  = b[14:10];
    p   = '0;
    top = '0;
    m   = '0;
    g   = 1'b0;
    st  = 1'b0;
    e   = '0;
    if ((ea == 5'h1f && a[9:0] != 10'h0) || (eb == 5'h1f && b[9:0] != 10'h0)) begin
      r = {1'b0, 16'h7e00};
    end else if (ea == 5'h1f || eb == 5'h1f) begin
      // inf * 0 is invalid; inf * finite is a plain infinity, not an error
      r = (ea == 5'h0 || eb == 5'h0) ? {1'b0, 16'h7e00} : {1'b0, s, 5'h1f, 10'h0};
    end else if (ea == 5'h0 || eb == 5'h0) begin
      r = {1'b0, s, 15'h0};
    end else begin
      p = {11'h0, 1'b1, a[9:0]} * {11'h0, 1'b1, b[9:0]};
      e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
      if (p[21]) begin
        top = p[21:11];
        g   = p[10];
        st  = |p[9:0];
        e   = e + 8'sd1;
      end else begin
        top = p[20:10];
        g   = p[9];
        st  = |p[8:0];
      end
      m = {1'b0, top} + {11'h0, g & (st | top[0])};
      if (m[11]) begin
        m = m >> 1;
        e = e + 8'sd1;
      end
      if (e >= 8'sd31)     r = {1'b1, s, 5'h1f, 10'h0};
      else if (e <= 8'sd0) r = {1'b1, s, 15'h0};
      else                 r = {1'b0, s, e[4:0], m[9:0]};
    end
    return r;
  endfunction

  // FP16 add with 12 extra fraction bits plus a sticky bit for rounding.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       x;
    logic [15:0]       y;
    logic [15:0]       r;
    logic [4:0]        ex;
    logic [4:0]        ey;
    logic [4:0]        d;
    logic [23:0]       mx;
    logic [23:0]       my;
    logic [23:0]       sh;
    logic [23:0]       sum;
    logic              lost;
    logic [10:0]       top;
    logic [11:0]       m;
    logic signed [7:0] e;
    int                lz;
    // x carries the larger magnitude
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex   = x[14:10];
    ey   = y[14:10];
    d    = ex - ey;
    mx   = {1'b0, 1'b1, x[9:0], 12'h0};
    my   = {1'b0, 1'b1, y[9:0], 12'h0};
    sh   = '0;
    sum  = '0;
    lost = 1'b0;
    top  = '0;
    m    = '0;
    e    = '0;
    lz   = 0;
    if (ex == 5'h1f || ey == 5'h1f) begin
      if ((ex == 5'h1f && x[9:0] != 10'h0) || (ey == 5'h1f && y[9:0] != 10'h0))
        r = 16'h7e00;
      else if (ex == 5'h1f && ey == 5'h1f && x[15] != y[15])
        r = 16'h7e00;
      else
        r = (ex == 5'h1f) ? x : y;
    end else if (ey == 5'h0) begin
      r = (ex == 5'h0) ? {x[15] & y[15], 15'h0} : x;
    end else begin
      sh    = my >> d;
      lost  = |(my & ~(24'hffffff << d));
      sh[0] = sh[0] | lost;
      sum   = (x[15] == y[15]) ? (mx + sh) : (mx - sh);
      e     = $signed({3'b000, ex});
      if (sum == 24'h0) begin
        r = 16'h0;
      end else begin
        if (sum[23]) begin
          sum = {1'b0, sum[23:2], sum[1] | sum[0]};
          e   = e + 8'sd1;
        end else begin
          // highest set bit wins, so lz ends as the normalising shift
          for (int i = 0; i <= 22; i++) begin
            if (sum[i]) lz = 22 - i;
          end
          sum = sum << lz;
          e   = e - 8'(lz);
        end
        top = sum[22:12];
        m   = {1'b0, top} + {11'h0, sum[11] & ((|sum[10:0]) | top[0])};
        if (m[11]) begin
          m = m >> 1;
          e = e + 8'sd1;
        end
        if (e >= 8'sd31)     r = {x[15], 5'h1f, 10'h0};
        else if (e <= 8'sd0) r = {x[15], 15'h0};
        else                 r = {x[15], e[4:0], m[9:0]};
      end
    end
    return r;
  endfunction

  // Mode-selected multiplier: {err, product}. INT8 products of the
  // sign-extended low bytes are exact in 16 bits.
  function automatic logic [16:0] mul16(input logic md, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ia;
    logic [15:0] ib;
    ia = {{8{a[7]}}, a[7:0]};
    ib = {{8{b[7]}}, b[7:0]};
    return md ? fp16_mul(a, b) : {1'b0, ia * ib};
  endfunction

  function automatic logic [15:0] add16(input logic md, input logic [15:0] a, input logic [15:0] b);
    return md ? fp16_add(a, b) : (a + b);
  endfunction

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic             r_mode;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [15:0]      r_acc;
  logic             r_err;

  logic             w_accept;
  logic             w_start_ok;
  logic             w_sum_valid;
  logic [15:0]      w_sum;
  logic             w_pipe_busy;

  assign in_ready   = (r_state == S_RUN);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign mac_out    = r_acc;
  assign error      = r_err;
  assign w_accept   = in_valid && (r_state == S_RUN);
  assign w_start_ok = start && (r_state == S_IDLE);

  // --------------------------------------------------------------------------
  // Stage 0: operand register. Stage 1: per-lane products.
  // --------------------------------------------------------------------------
  logic                r_v0;
  logic [16*LANES-1:0] r_opa;
  logic [16*LANES-1:0] r_opb;
  logic                r_v1;
  logic [15:0]         r_prod [LANES];
  logic [16:0]         w_mul  [LANES];
  logic                w_mul_err;
  logic [15:0]         w_tree;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_mul[k] = mul16(r_mode, r_opa[16*k +: 16], r_opb[16*k +: 16]);
    end
  endgenerate

  always_comb begin
    w_mul_err = 1'b0;
    for (int k = 0; k < LANES; k++) w_mul_err = w_mul_err | w_mul[k][16];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0  <= 1'b0;
      r_opa <= '0;
      r_opb <= '0;
      r_v1  <= 1'b0;
      for (int k = 0; k < LANES; k++) r_prod[k] <= '0;
    end else begin
      r_v0 <= w_accept;
      if (w_accept) begin
        r_opa <= in_a;
        r_opb <= in_b;
      end
      r_v1 <= r_v0;
      if (r_v0) begin
        for (int k = 0; k < LANES; k++) r_prod[k] <= w_mul[k][15:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: balanced adder tree, reduced in place level by level. Pairs
  // (2k, 2k+1) feed slot k, so lane order is preserved at every level.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [15:0] t [LANES];
    for (int k = 0; k < LANES; k++) t[k] = r_prod[k];
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int k = 0; k < w; k++) t[k] = add16(r_mode, t[2*k], t[2*k+1]);
    end
    w_tree = t[0];
  end

`ifdef MAC_TREE_REG_EN
  logic        r_v2;
  logic [15:0] r_tree;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_tree <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_tree <= w_tree;
    end
  end

  assign w_sum_valid = r_v2;
  assign w_sum       = r_tree;
  assign w_pipe_busy = r_v0 | r_v1 | r_v2;
`else
  assign w_sum_valid = r_v1;
  assign w_sum       = w_tree;
  assign w_pipe_busy = r_v0 | r_v1;
`endif

  // --------------------------------------------------------------------------
  // Stage 3 accumulator and job FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
    end else begin
      // The pipeline is empty whenever a start is taken, so the seed never
      // collides with an accumulate.
      if (w_start_ok)       r_acc <= in_c;
      else if (w_sum_valid) r_acc <= add16(r_mode, r_acc, w_sum);

      if (w_start_ok)                      r_err <= 1'b0;
      else if (r_v0 && r_mode && w_mul_err) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_mode  <= mode;
            r_len   <= len;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_cnt == r_len) r_state <= S_DRAIN;
            else                r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!w_pipe_busy) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
